// File: rtl/pll_speed_ctrl_if.sv
// pll_speed_ctrl_if: Avalon-MM write-only management link between the
// speed controller (master) and the PLL reconfiguration controller (slave).
interface pll_speed_ctrl_if;
   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;

   modport master (
      output mgmt_address,
      output mgmt_write,
      output mgmt_writedata,
      input  mgmt_waitrequest
   );

   modport slave (
      input  mgmt_address,
      input  mgmt_write,
      input  mgmt_writedata,
      output mgmt_waitrequest
   );
endinterface

// File: rtl/pll_speed_ctrl.sv
// pll_speed_ctrl: sequences PLL output-counter reprogramming for CPU turbo
// speed switching. Writes mode, C-counter and start registers of the PLL
// reconfig controller, then holds the CPU clock gate until the PLL has been
// locked for SETTLE consecutive cycles.
// Optional lock-timeout supervision is enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_speed_ctrl #(
   parameter int unsigned C_SEL        = 1,
   parameter int unsigned DIV_0        = 293,
   parameter int unsigned DIV_1        = 196,
   parameter int unsigned DIV_2        = 147,
   parameter int unsigned DIV_3        = 49,
   parameter int unsigned INIT_SPEED   = 0,
   parameter int unsigned SETTLE       = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              speed_sel,
   input  logic                    pll_locked,
   pll_speed_ctrl_if.master        mgmt,
   output logic [1:0]              cur_speed,
   output logic                    busy,
   output logic                    clk_hold,
   output logic                    err
);

   localparam int unsigned SET_W = $clog2(SETTLE + 1);

   localparam logic [5:0] ADDR_MODE  = 6'h00;
   localparam logic [5:0] ADDR_CCNT  = 6'h05;
   localparam logic [5:0] ADDR_START = 6'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_MODE,
      S_GAP_MODE,
      S_WR_CCNT,
      S_GAP_CCNT,
      S_WR_START,
      S_WAIT_LOCK,
      S_DONE
   } state_t;

   // Total divide N -> C-counter word: high/low counts plus odd-duty bit.
   function automatic logic [31:0] ccnt_word(input int unsigned n);
      logic [9:0]  nn;
      logic [9:0]  hi;
      logic [9:0]  lo;
      logic [31:0] w;
      nn        = 10'(n);
      hi        = (nn + 10'd1) >> 1;
      lo        = nn >> 1;
      w         = '0;
      w[22:18]  = 5'(C_SEL);
      w[17]     = nn[0];
      w[16]     = 1'b0;
      w[15:8]   = hi[7:0];
      w[7:0]    = lo[7:0];
      return w;
   endfunction

   function automatic int unsigned div_of(input logic [1:0] s);
      int unsigned d;
      case (s)
         2'd0:    d = DIV_0;
         2'd1:    d = DIV_1;
         2'd2:    d = DIV_2;
         default: d = DIV_3;
      endcase
      return d;
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        target_q, target_d;
   logic [1:0]        cur_speed_q, cur_speed_d;
   logic              busy_q, busy_d;
   logic              clk_hold_q, clk_hold_d;
   logic [5:0]        addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [31:0]       data_q, data_d;
   logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
   logic              err_q, err_d;

`ifdef PLL_LOCK_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
`endif

   // Next-state and registered-output computation for the reconfig sequencer.
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      cur_speed_d = cur_speed_q;
      busy_d      = busy_q;
      clk_hold_d  = clk_hold_q;
      addr_d      = addr_q;
      wr_d        = wr_q;
      data_d      = data_q;
      set_cnt_d   = set_cnt_q;
      err_d       = err_q;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (speed_sel != cur_speed_q) begin
               target_d   = speed_sel;
               busy_d     = 1'b1;
               clk_hold_d = 1'b1;
               wr_d       = 1'b1;
               addr_d     = ADDR_MODE;
               data_d     = '0;
               state_d    = S_WR_MODE;
            end
         end

         S_WR_MODE: begin
            if (!mgmt.mgmt_waitrequest) begin
               wr_d    = 1'b0;
               state_d = S_GAP_MODE;
            end
         end

         S_GAP_MODE: begin
            wr_d    = 1'b1;
            addr_d  = ADDR_CCNT;
            data_d  = ccnt_word(div_of(target_q));
            state_d = S_WR_CCNT;
         end

         S_WR_CCNT: begin
            if (!mgmt.mgmt_waitrequest) begin
               wr_d    = 1'b0;
               state_d = S_GAP_CCNT;
            end
         end

         S_GAP_CCNT: begin
            wr_d    = 1'b1;
            addr_d  = ADDR_START;
            data_d  = 32'd1;
            state_d = S_WR_START;
         end

         S_WR_START: begin
            if (!mgmt.mgmt_waitrequest) begin
               wr_d      = 1'b0;
               set_cnt_d = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
               state_d   = S_WAIT_LOCK;
            end
         end

         // Completion results are registered on entry to DONE so that
         // cur_speed/busy/clk_hold already show final values during DONE.
         S_WAIT_LOCK: begin
            if (pll_locked) begin
               set_cnt_d = set_cnt_q + 1'b1;
            end else begin
               set_cnt_d = '0;
            end
`ifdef PLL_LOCK_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
            if (pll_locked && (set_cnt_d == SET_W'(SETTLE))) begin
               cur_speed_d = target_q;
               busy_d      = 1'b0;
               clk_hold_d  = 1'b0;
               state_d     = S_DONE;
            end
`ifdef PLL_LOCK_TIMEOUT_EN
            else if (tmo_cnt_d == TMO_W'(LOCK_TIMEOUT)) begin
               err_d      = 1'b1;
               busy_d     = 1'b0;
               clk_hold_d = 1'b0;
               state_d    = S_DONE;
            end
`endif
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         target_q    <= 2'(INIT_SPEED);
         cur_speed_q <= 2'(INIT_SPEED);
         busy_q      <= 1'b0;
         clk_hold_q  <= 1'b0;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         data_q      <= '0;
         set_cnt_q   <= '0;
         err_q       <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         cur_speed_q <= cur_speed_d;
         busy_q      <= busy_d;
         clk_hold_q  <= clk_hold_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         data_q      <= data_d;
         set_cnt_q   <= set_cnt_d;
         err_q       <= err_d;
`ifdef PLL_LOCK_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
`endif
      end
   end

   assign mgmt.mgmt_address   = addr_q;
   assign mgmt.mgmt_write     = wr_q;
   assign mgmt.mgmt_writedata = data_q;
   assign cur_speed           = cur_speed_q;
   assign busy                = busy_q;
   assign clk_hold            = clk_hold_q;
   assign err                 = err_q;

endmodule

// File: tb/tb_pll_speed_ctrl.sv
// tb_pll_speed_ctrl: directed-vector bench with a write scoreboard for
// pll_speed_ctrl. Expected Avalon writes are queued by the stimulus and
// checked by an independent bus monitor.
module tb_pll_speed_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] speed_sel;
   logic       pll_locked;
   logic [1:0] cur_speed;
   logic       busy;
   logic       clk_hold;
   logic       err;

   pll_speed_ctrl_if u_if ();

   pll_speed_ctrl #(
      .LOCK_TIMEOUT (100)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .speed_sel  (speed_sel),
      .pll_locked (pll_locked),
      .mgmt       (u_if),
      .cur_speed  (cur_speed),
      .busy       (busy),
      .clk_hold   (clk_hold),
      .err        (err)
   );

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int start_cnt = 0;
   int accept_cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [5:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
   endtask

   task automatic push_seq(input logic [31:0] ccnt);
      push(6'h00, 32'h0);
      push(6'h05, ccnt);
      push(6'h02, 32'h1);
   endtask

   // Bus monitor: checks accepted writes, stall stability and write spacing.
   initial begin
      logic        stall_v;
      logic        prev_acc;
      logic [5:0]  held_a;
      logic [31:0] held_d;
      wr_t         w;
      stall_v  = 1'b0;
      prev_acc = 1'b0;
      held_a   = '0;
      held_d   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_v  = 1'b0;
            prev_acc = 1'b0;
         end else begin
            if (stall_v) begin
               chk("stall_write_held", {31'd0, u_if.mgmt_write}, 32'd1);
               chk("stall_addr_held", {26'd0, u_if.mgmt_address}, {26'd0, held_a});
               chk("stall_data_held", u_if.mgmt_writedata, held_d);
            end
            if (prev_acc) begin
               chk("write_gap_after_accept", {31'd0, u_if.mgmt_write}, 32'd0);
            end
            stall_v  = 1'b0;
            prev_acc = 1'b0;
            if (u_if.mgmt_write) begin
               if (u_if.mgmt_waitrequest) begin
                  stall_v = 1'b1;
                  held_a  = u_if.mgmt_address;
                  held_d  = u_if.mgmt_writedata;
               end else begin
                  prev_acc = 1'b1;
                  if (exp_q.size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                              u_if.mgmt_address, u_if.mgmt_writedata);
                  end else begin
                     w = exp_q.pop_front();
                     chk("write_addr", {26'd0, u_if.mgmt_address}, {26'd0, w.a});
                     chk("write_data", u_if.mgmt_writedata, w.d);
                  end
                  if (u_if.mgmt_address == 6'h02) begin
                     accept_cyc = cyc + 1;
                     start_cnt++;
                  end
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int base, input int maxc);
      int n;
      n = 0;
      while (start_cnt == base && n < maxc) begin
         tick(1);
         n++;
      end
      chk("start_write_seen", {31'd0, (start_cnt != base)}, 32'd1);
   endtask

   task automatic wait_busy(input logic lvl, input int maxc, output int at);
      int n;
      n = 0;
      while (busy !== lvl && n < maxc) begin
         tick(1);
         n++;
      end
      chk(lvl ? "busy_rise" : "busy_fall", {31'd0, busy}, {31'd0, lvl});
      at = cyc;
   endtask

   task automatic wait_ccnt_write(input int maxc);
      int n;
      n = 0;
      while (!(u_if.mgmt_write && u_if.mgmt_address == 6'h05) && n < maxc) begin
         tick(1);
         n++;
      end
      chk("ccnt_write_seen", {31'd0, u_if.mgmt_write}, 32'd1);
   endtask

   initial begin
      int at;
      int base;
      int rise;
      rst_n                 = 1'b0;
      speed_sel             = 2'd0;
      pll_locked            = 1'b1;
      u_if.mgmt_waitrequest = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(5);

      // Reset / idle state
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_clk_hold", {31'd0, clk_hold}, 32'd0);
      chk("reset_cur_speed", {30'd0, cur_speed}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_write", {31'd0, u_if.mgmt_write}, 32'd0);

      // 0 -> 2, N=147: odd=1 hi=74 lo=73 -> 0x00064A49
      base = start_cnt;
      push_seq(32'h0006_4A49);
      speed_sel = 2'd2;
      tick(1);
      chk("req_busy", {31'd0, busy}, 32'd1);
      chk("req_clk_hold", {31'd0, clk_hold}, 32'd1);
      wait_start(base, 40);
      chk("wait_clk_hold", {31'd0, clk_hold}, 32'd1);
      wait_busy(1'b0, 40, at);
      chk("settle_latency", at - accept_cyc, 16);
      chk("cur_speed_2", {30'd0, cur_speed}, 32'd2);
      chk("done_clk_hold", {31'd0, clk_hold}, 32'd0);

      // 2 -> 3 with 5-cycle stall on C-counter write, locked low 20 cycles.
      // N=49: odd=1 hi=25 lo=24 -> 0x00061918
      tick(3);
      pll_locked = 1'b0;
      base = start_cnt;
      push_seq(32'h0006_1918);
      speed_sel = 2'd3;
      wait_ccnt_write(20);
      u_if.mgmt_waitrequest = 1'b1;
      tick(5);
      chk("ccnt_still_stalled", {31'd0, u_if.mgmt_write}, 32'd1);
      chk("no_start_during_stall", start_cnt, base);
      u_if.mgmt_waitrequest = 1'b0;
      wait_start(base, 20);
      tick(20);
      chk("busy_while_unlocked", {31'd0, busy}, 32'd1);
      pll_locked = 1'b1;
      rise = cyc;
      wait_busy(1'b0, 40, at);
      chk("lock_rise_latency", at - rise, 16);
      chk("cur_speed_3", {30'd0, cur_speed}, 32'd3);

      // 3 -> 0 with lock glitch at count 10. N=293: odd=1 hi=147 lo=146
      tick(3);
      pll_locked = 1'b0;
      base = start_cnt;
      push_seq(32'h0006_9392);
      speed_sel = 2'd0;
      wait_start(base, 40);
      tick(3);
      pll_locked = 1'b1;
      tick(10);
      chk("busy_before_glitch", {31'd0, busy}, 32'd1);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      rise = cyc;
      wait_busy(1'b0, 40, at);
      chk("glitch_restart_latency", at - rise, 16);
      chk("cur_speed_0", {30'd0, cur_speed}, 32'd0);

      // Last request wins: 0 -> 3, then 1 while busy. N=196 -> 0x00046262
      tick(3);
      push_seq(32'h0006_1918);
      push_seq(32'h0004_6262);
      speed_sel = 2'd3;
      tick(2);
      speed_sel = 2'd1;
      wait_busy(1'b0, 60, at);
      chk("first_seq_cur_speed_3", {30'd0, cur_speed}, 32'd3);
      wait_busy(1'b1, 5, at);
      wait_busy(1'b0, 60, at);
      chk("second_seq_cur_speed_1", {30'd0, cur_speed}, 32'd1);

      // Equal request and lock drop in idle: nothing happens.
      tick(10);
      chk("equal_req_idle", {31'd0, busy}, 32'd0);
      pll_locked = 1'b0;
      tick(5);
      chk("lock_drop_idle_busy", {31'd0, busy}, 32'd0);
      chk("lock_drop_idle_hold", {31'd0, clk_hold}, 32'd0);
      chk("lock_drop_idle_speed", {30'd0, cur_speed}, 32'd1);

      // Lock never returns.
      base = start_cnt;
      push_seq(32'h0006_4A49);
      speed_sel = 2'd2;
      wait_start(base, 40);
`ifdef PLL_LOCK_TIMEOUT_EN
      wait_busy(1'b0, 150, at);
      speed_sel = 2'd1;
      chk("timeout_latency", at - accept_cyc, 100);
      chk("timeout_err", {31'd0, err}, 32'd1);
      chk("timeout_cur_speed", {30'd0, cur_speed}, 32'd1);
      chk("timeout_clk_hold", {31'd0, clk_hold}, 32'd0);
      tick(5);
      chk("timeout_err_sticky", {31'd0, err}, 32'd1);
      chk("timeout_idle", {31'd0, busy}, 32'd0);
`else
      tick(200);
      chk("no_timeout_busy", {31'd0, busy}, 32'd1);
      chk("no_timeout_err", {31'd0, err}, 32'd0);
      chk("no_timeout_hold", {31'd0, clk_hold}, 32'd1);
      chk("no_timeout_cur_speed", {30'd0, cur_speed}, 32'd1);
`endif
      rst_n      = 1'b0;
      speed_sel  = 2'd0;
      pll_locked = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      chk("rereset_err", {31'd0, err}, 32'd0);
      chk("rereset_cur_speed", {30'd0, cur_speed}, 32'd0);

      // Reset while the C-counter write is stalled.
      push(6'h00, 32'h0);
      speed_sel = 2'd2;
      wait_ccnt_write(20);
      u_if.mgmt_waitrequest = 1'b1;
      tick(3);
      rst_n = 1'b0;
      tick(1);
      chk("rst_stall_write", {31'd0, u_if.mgmt_write}, 32'd0);
      chk("rst_stall_busy", {31'd0, busy}, 32'd0);
      chk("rst_stall_hold", {31'd0, clk_hold}, 32'd0);
      chk("rst_stall_cur_speed", {30'd0, cur_speed}, 32'd0);
      speed_sel             = 2'd0;
      u_if.mgmt_waitrequest = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(5);
      chk("post_reset_idle", {31'd0, busy}, 32'd0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
